// File: rtl/datamem_bytelane_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : datamem_pkg
//  Description : Shared encodings for the byte-lane data memory: access size
//                codes, sweep/ready FSM states and byte-enable helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package datamem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_X = 2'b11;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Byte enables for an aligned access; an illegal size touches no lane.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr);
        logic [3:0] mask;
        mask = 4'b0000;
        case (size)
            SIZE_B:  mask = 4'b0001 << addr;
            SIZE_H:  mask = addr[1] ? 4'b1100 : 4'b0011;
            SIZE_W:  mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // Alignment fault, independent of whether a request is present.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_H:  bad = addr[0];
            SIZE_W:  bad = (addr != 2'b00);
            SIZE_X:  bad = 1'b1;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/datamem_bytelane_if.sv
`default_nettype none
// ============================================================================
//  Module      : datamem_bytelane_if
//  Description : CPU-side load/store bus of the byte-lane data memory.
//                master = datapath, slave = memory.
//  Revision    : 1.0  initial release
// ============================================================================
interface datamem_bytelane_if #(
    parameter int ADDR_WIDTH = 11
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  mem_write;
    logic                  mem_read;
    logic [1:0]            size;
    logic                  load_unsigned;
    logic [31:0]           write_data;
    logic [31:0]           read_data;
    logic                  misaligned;
    logic                  busy;

    modport master (
        output address, mem_write, mem_read, size, load_unsigned, write_data,
        input  read_data, misaligned, busy
    );

    modport slave (
        input  address, mem_write, mem_read, size, load_unsigned, write_data,
        output read_data, misaligned, busy
    );
endinterface
`default_nettype wire

// File: rtl/datamem_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : datamem_load_align
//  Description : Selects the addressed byte/half from a 32-bit word and
//                sign- or zero-extends it. Word loads pass straight through.
//  Revision    : 1.0  initial release
// ============================================================================
module datamem_load_align
    import datamem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr,
    input  logic [1:0]  i_size,
    input  logic        i_load_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane select followed by extension according to access size.
    always_comb begin
        w_byte = 8'h00;
        w_half = 16'h0000;
        o_data = 32'h0000_0000;
        case (i_addr)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];
        case (i_size)
            SIZE_B:  o_data = i_load_unsigned ? {24'h000000, w_byte}
                                              : {{24{w_byte[7]}}, w_byte};
            SIZE_H:  o_data = i_load_unsigned ? {16'h0000, w_half}
                                              : {{16{w_half[15]}}, w_half};
            SIZE_W:  o_data = i_word;
            default: o_data = 32'h0000_0000;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/datamem_bytelane.sv
`default_nettype none
// ============================================================================
//  Module      : datamem_bytelane
//  Description : Data memory with byte/half/word loads and stores, sign/zero
//                extension, misalignment detection and an optional zeroing
//                sweep after reset during which the CPU is stalled via busy.
//  Revision    : 1.0  initial release
// ============================================================================
module datamem_bytelane
    import datamem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 11,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    datamem_bytelane_if.slave    bus
);

    localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
    localparam int PTR_W = ADDR_WIDTH - 2;

    localparam state_t          c_reset_state = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
    localparam logic [PTR_W-1:0] c_last_idx   = {PTR_W{1'b1}};

    logic [31:0]      r_mem [0:DEPTH-1];
    state_t           r_state;
    state_t           w_state_next;
    logic [PTR_W-1:0] r_clr_ptr;

    logic             w_busy;
    logic             w_active;
    logic             w_mis_raw;
    logic [PTR_W-1:0] w_word_idx;
    logic [31:0]      w_rd_word;
    logic [31:0]      w_load_data;
    logic             w_store_en;
    logic             w_clear_en;
    logic [3:0]       w_lane_we;
    logic [PTR_W-1:0] w_wr_idx;
    logic [31:0]      w_wr_data;
    logic [31:0]      w_store_data;

    // Reset forces the sweep (or READY when clearing is disabled).
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_reset_state;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Leave CLEAR on the edge that zeroes the last word; READY is terminal.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_CLEAR: if (r_clr_ptr == c_last_idx) w_state_next = ST_READY;
            default:  w_state_next = ST_READY;
        endcase
    end

    // Sweep pointer restarts at word 0 on every reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_clr_ptr <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_ptr <= r_clr_ptr + 1'b1;
        end
    end

    // Request qualification: nothing happens while reset is held or sweeping.
    assign w_busy     = reset | (r_state == ST_CLEAR);
    assign w_active   = (bus.mem_read | bus.mem_write) & ~w_busy;
    assign w_mis_raw  = is_misaligned(bus.size, bus.address[1:0]);
    assign w_word_idx = bus.address[ADDR_WIDTH-1:2];
    assign w_rd_word  = r_mem[w_word_idx];

    assign w_store_en = w_active & bus.mem_write & ~w_mis_raw;
    assign w_clear_en = (r_state == ST_CLEAR) & ~reset;

    // Replicate sub-word store data onto every lane; enables pick the target.
    always_comb begin
        w_store_data = bus.write_data;
        case (bus.size)
            SIZE_B:  w_store_data = {4{bus.write_data[7:0]}};
            SIZE_H:  w_store_data = {2{bus.write_data[15:0]}};
            default: w_store_data = bus.write_data;
        endcase
    end

    // The sweep and CPU stores never overlap, so one write port serves both.
    always_comb begin
        w_wr_idx  = w_word_idx;
        w_wr_data = w_store_data;
        w_lane_we = 4'b0000;
        if (w_clear_en) begin
            w_wr_idx  = r_clr_ptr;
            w_wr_data = 32'h0000_0000;
            w_lane_we = 4'b1111;
        end else if (w_store_en) begin
            w_lane_we = lane_mask(bus.size, bus.address[1:0]);
        end
    end

    // Per-lane array write; untouched lanes keep their contents.
    always_ff @(posedge clock) begin
        for (int k = 0; k < 4; k++) begin
            if (w_lane_we[k]) begin
                r_mem[w_wr_idx][8*k +: 8] <= w_wr_data[8*k +: 8];
            end
        end
    end

    datamem_load_align u_load_align (
        .i_word          (w_rd_word),
        .i_addr          (bus.address[1:0]),
        .i_size          (bus.size),
        .i_load_unsigned (bus.load_unsigned),
        .o_data          (w_load_data)
    );

    // Loads read the pre-write array, so a same-cycle store shows next cycle.
    assign bus.read_data  = (w_active & bus.mem_read & ~w_mis_raw) ? w_load_data : 32'h0000_0000;
    assign bus.misaligned = w_active & w_mis_raw;
    assign bus.busy       = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_datamem_bytelane.sv
`default_nettype none
// ============================================================================
//  Module      : tb_datamem_bytelane
//  Description : Directed vector bench for datamem_bytelane.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_datamem_bytelane;
    import datamem_pkg::*;

    localparam int ADDR_WIDTH = 11;
    localparam int DEPTH      = 512;

    typedef struct {
        string       name;
        logic        we;
        logic        re;
        logic [1:0]  sz;
        logic        uns;
        logic [10:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_mis;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs[$];

    datamem_bytelane_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

    datamem_bytelane #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic re, input logic [1:0] sz,
                         input logic uns, input logic [10:0] addr, input logic [31:0] wd);
        bus.mem_write     = we;
        bus.mem_read      = re;
        bus.size          = sz;
        bus.load_unsigned = uns;
        bus.address       = addr;
        bus.write_data    = wd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, SIZE_W, 1'b0, 11'h000, 32'h0);
    endtask

    function automatic void add(input string n, input logic we, input logic re,
                                input logic [1:0] sz, input logic uns, input logic [10:0] addr,
                                input logic [31:0] wd, input logic [31:0] rd, input logic mis);
        vec_t v;
        v.name = n; v.we = we; v.re = re; v.sz = sz; v.uns = uns;
        v.addr = addr; v.wd = wd; v.exp_rd = rd; v.exp_mis = mis;
        vecs.push_back(v);
    endfunction

    initial begin
        int n;
        logic bad;
        checks = 0;
        errors = 0;

        // name                 we  re  size   uns addr    wdata          exp_rd         mis
        add("sw_10",            1, 0, SIZE_W, 0, 11'h010, 32'h11223344, 32'h00000000, 0);
        add("sb_11",            1, 0, SIZE_B, 0, 11'h011, 32'hFFFFFFAB, 32'h00000000, 0);
        add("lw_10",            0, 1, SIZE_W, 0, 11'h010, 32'h0,        32'h1122AB44, 0);
        add("lb_11",            0, 1, SIZE_B, 0, 11'h011, 32'h0,        32'hFFFFFFAB, 0);
        add("lbu_11",           0, 1, SIZE_B, 1, 11'h011, 32'h0,        32'h000000AB, 0);
        add("lb_13",            0, 1, SIZE_B, 0, 11'h013, 32'h0,        32'h00000011, 0);
        add("lh_10",            0, 1, SIZE_H, 0, 11'h010, 32'h0,        32'hFFFFAB44, 0);
        add("sh_22",            1, 0, SIZE_H, 0, 11'h022, 32'h12348001, 32'h00000000, 0);
        add("lw_20",            0, 1, SIZE_W, 0, 11'h020, 32'h0,        32'h80010000, 0);
        add("lw_20_uns",        0, 1, SIZE_W, 1, 11'h020, 32'h0,        32'h80010000, 0);
        add("lh_22",            0, 1, SIZE_H, 0, 11'h022, 32'h0,        32'hFFFF8001, 0);
        add("lhu_22",           0, 1, SIZE_H, 1, 11'h022, 32'h0,        32'h00008001, 0);
        add("sw_30",            1, 0, SIZE_W, 0, 11'h030, 32'h55667788, 32'h00000000, 0);
        add("sw_31_mis",        1, 0, SIZE_W, 0, 11'h031, 32'hFFFFFFFF, 32'h00000000, 1);
        add("lh_33_mis",        0, 1, SIZE_H, 0, 11'h033, 32'h0,        32'h00000000, 1);
        add("sx_30_mis",        1, 0, SIZE_X, 0, 11'h030, 32'hFFFFFFFF, 32'h00000000, 1);
        add("lx_30_mis",        0, 1, SIZE_X, 0, 11'h030, 32'h0,        32'h00000000, 1);
        add("sh_31_mis",        1, 0, SIZE_H, 0, 11'h031, 32'hFFFFFFFF, 32'h00000000, 1);
        add("lw_30_kept",       0, 1, SIZE_W, 0, 11'h030, 32'h0,        32'h55667788, 0);
        add("no_req_mis",       0, 0, SIZE_W, 0, 11'h031, 32'hFFFFFFFF, 32'h00000000, 0);
        add("sw_40",            1, 0, SIZE_W, 0, 11'h040, 32'hCAFEF00D, 32'h00000000, 0);
        add("rw_40_old",        1, 1, SIZE_W, 0, 11'h040, 32'hDEADBEEF, 32'hCAFEF00D, 0);
        add("lw_40_new",        0, 1, SIZE_W, 0, 11'h040, 32'h0,        32'hDEADBEEF, 0);
        add("sb_43",            1, 0, SIZE_B, 0, 11'h043, 32'h0000007F, 32'h00000000, 0);
        add("lw_40_sb",         0, 1, SIZE_W, 0, 11'h040, 32'h0,        32'h7FADBEEF, 0);
        add("lhu_40",           0, 1, SIZE_H, 1, 11'h040, 32'h0,        32'h0000BEEF, 0);
        add("lb_42",            0, 1, SIZE_B, 0, 11'h042, 32'h0,        32'hFFFFFFAD, 0);

        // First reset: busy and quiet outputs while reset is held.
        rst = 1'b1;
        drive(1'b0, 1'b1, SIZE_W, 1'b0, 11'h000, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("busy_in_reset", {31'h0, bus.busy}, 32'h1);
        chk("rd_in_reset", bus.read_data, 32'h0);
        chk("mis_in_reset", {31'h0, bus.misaligned}, 32'h0);
        idle();
        rst = 1'b0;

        n = 0;
        while (bus.busy === 1'b1 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("sweep1_len", n, DEPTH);

        // Every word reads back zero after the sweep.
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, SIZE_W, 1'b0, 11'(i * 4), 32'h0);
            #1;
            chk($sformatf("lw_clr_%0d", i), bus.read_data, 32'h0);
        end

        // Table-driven vectors: outputs checked before the committing edge.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].re, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd);
            #1;
            chk({vecs[i].name, "_rd"}, bus.read_data, vecs[i].exp_rd);
            chk({vecs[i].name, "_mis"}, {31'h0, bus.misaligned}, {31'h0, vecs[i].exp_mis});
        end
        @(negedge clk);
        idle();

        // Reset reasserted 100 cycles into a sweep restarts it from word 0.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("busy_mid_sweep", {31'h0, bus.busy}, 32'h1);
        rst = 1'b1;
        drive(1'b1, 1'b1, SIZE_W, 1'b0, 11'h050, 32'h12345678);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        bad = 1'b0;
        while (bus.busy === 1'b1 && n < 2000) begin
            if (bus.read_data !== 32'h0 || bus.misaligned !== 1'b0) bad = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        idle();
        chk("sweep2_len", n, DEPTH);
        chk("busy_outputs_quiet", {31'h0, bad}, 32'h0);

        @(negedge clk);
        drive(1'b0, 1'b1, SIZE_W, 1'b0, 11'h050, 32'h0);
        #1;
        chk("lw_50_dropped", bus.read_data, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b1, SIZE_W, 1'b0, 11'h010, 32'h0);
        #1;
        chk("lw_10_recleared", bus.read_data, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b1, SIZE_W, 1'b0, 11'h040, 32'h0);
        #1;
        chk("lw_40_recleared", bus.read_data, 32'h0);
        @(negedge clk);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
